// File: rtl/l2_bus_op_unit_pkg.sv
// Shared encodings for the L2 bus operation unit: bus op codes, snoop
// results, FSM states and small decode helpers.
package l2_bus_pkg;

    typedef enum logic [2:0] {
        NOP        = 3'd0,
        READ       = 3'd1,
        WRITE      = 3'd2,
        INVALIDATE = 3'd3,
        RFO        = 3'd4
    } bus_op_e;

    typedef enum logic [1:0] {
        NOHIT = 2'b00,
        HIT   = 2'b01,
        HITM  = 2'b10
    } snoop_e;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        SNOOP,
        DATA,
        RESP
    } state_e;

    // Only READ..RFO drive a bus transaction; everything else is answered locally.
    function automatic logic op_legal(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    // The reserved snoop code 2'b11 is folded into HITM.
    function automatic snoop_e snoop_norm(input logic [1:0] s);
        return (s == 2'b11) ? HITM : snoop_e'(s);
    endfunction

endpackage

// File: rtl/l2_bus_op_unit_if.sv
// Controller request/response handshake plus shared-bus signals.
// slave: the bus operation unit; master: controller and bus side.
interface l2_bus_op_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [1:0]        rsp_snoop;
    logic              bus_valid;
    logic [2:0]        bus_op;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_snoop_valid;
    logic [1:0]        bus_snoop;
    logic              bus_beat;

    modport slave (
        input  req_valid, req_op, req_addr, bus_snoop_valid, bus_snoop, bus_beat,
        output req_ready, rsp_valid, rsp_snoop, bus_valid, bus_op, bus_addr
    );

    modport master (
        output req_valid, req_op, req_addr, bus_snoop_valid, bus_snoop, bus_beat,
        input  req_ready, rsp_valid, rsp_snoop, bus_valid, bus_op, bus_addr
    );
endinterface

// File: rtl/l2_bus_op_unit_stat_counter.sv
// Saturating statistics counter with an increment enable.
module l2_bus_stat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, holding at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/l2_bus_op_unit.sv
// Executes one controller bus operation at a time as a shared-bus
// transaction (address, snoop, optional data phase, response) and keeps
// per-operation statistics.
module l2_bus_op_unit
    import l2_bus_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned OFFSET_W   = 6,
    parameter int unsigned DATA_BEATS = 4,
    parameter int unsigned SNOOP_TMO  = 15,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    l2_bus_op_unit_if.slave  bif,
    output logic [CNT_W-1:0] cnt_read,
    output logic [CNT_W-1:0] cnt_write,
    output logic [CNT_W-1:0] cnt_modify,
    output logic [CNT_W-1:0] cnt_invalid,
    output logic             err_snoop_tmo
);

    localparam int unsigned TMO_W  = $clog2(SNOOP_TMO + 1);
    localparam int unsigned BEAT_W = $clog2(DATA_BEATS + 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_W;

    state_e            state;
    logic              req_ready_q;
    logic              rsp_valid_q;
    snoop_e            rsp_snoop_q;
    snoop_e            snoop_q;
    logic              bus_valid_q;
    bus_op_e           bus_op_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [BEAT_W-1:0] beat_cnt;

    logic              snoop_done;
    logic              snoop_tmo;
    snoop_e            snoop_res;

    assign bif.req_ready = req_ready_q;
    assign bif.rsp_valid = rsp_valid_q;
    assign bif.rsp_snoop = rsp_snoop_q;
    assign bif.bus_valid = bus_valid_q;
    assign bif.bus_op    = bus_op_q;
    assign bif.bus_addr  = bus_addr_q;

    // Resolve the snoop phase this cycle; a real response beats a same-cycle timeout.
    always_comb begin
        snoop_done = 1'b0;
        snoop_tmo  = 1'b0;
        snoop_res  = NOHIT;
        if (state == SNOOP) begin
            if (bif.bus_snoop_valid) begin
                snoop_done = 1'b1;
                snoop_res  = snoop_norm(bif.bus_snoop);
            end else if (tmo_cnt == TMO_W'(SNOOP_TMO - 1)) begin
                snoop_done = 1'b1;
                snoop_tmo  = 1'b1;
            end
        end
    end

    // Transaction sequencer with registered handshake and bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_snoop_q   <= NOHIT;
            snoop_q       <= NOHIT;
            bus_valid_q   <= 1'b0;
            bus_op_q      <= NOP;
            bus_addr_q    <= '0;
            tmo_cnt       <= '0;
            beat_cnt      <= '0;
            err_snoop_tmo <= 1'b0;
        end else begin
            rsp_valid_q   <= 1'b0;
            bus_valid_q   <= 1'b0;
            err_snoop_tmo <= 1'b0;
            case (state)
                IDLE: begin
                    if (bif.req_valid) begin
                        req_ready_q <= 1'b0;
                        if (op_legal(bif.req_op)) begin
                            state       <= ADDR;
                            bus_valid_q <= 1'b1;
                            bus_op_q    <= bus_op_e'(bif.req_op);
                            bus_addr_q  <= bif.req_addr & LINE_MASK;
                        end else begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_snoop_q <= NOHIT;
                        end
                    end
                end
                ADDR: begin
                    state   <= SNOOP;
                    tmo_cnt <= '0;
                end
                SNOOP: begin
                    if (snoop_done) begin
                        snoop_q       <= snoop_res;
                        err_snoop_tmo <= snoop_tmo;
                        if (bus_op_q == INVALIDATE) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_snoop_q <= snoop_res;
                        end else begin
                            state    <= DATA;
                            beat_cnt <= '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                DATA: begin
                    if (bif.bus_beat) begin
                        if (beat_cnt == BEAT_W'(DATA_BEATS - 1)) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_snoop_q <= snoop_q;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_snoop_q <= NOHIT;
                    bus_op_q    <= NOP;
                    bus_addr_q  <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    l2_bus_stat_counter #(.CNT_W(CNT_W)) u_cnt_read (
        .clk(clk), .rst(rst), .inc((state == ADDR) && (bus_op_q == READ)), .count(cnt_read)
    );
    l2_bus_stat_counter #(.CNT_W(CNT_W)) u_cnt_write (
        .clk(clk), .rst(rst), .inc((state == ADDR) && (bus_op_q == WRITE)), .count(cnt_write)
    );
    l2_bus_stat_counter #(.CNT_W(CNT_W)) u_cnt_modify (
        .clk(clk), .rst(rst), .inc((state == ADDR) && (bus_op_q == RFO)), .count(cnt_modify)
    );
    l2_bus_stat_counter #(.CNT_W(CNT_W)) u_cnt_invalid (
        .clk(clk), .rst(rst), .inc((state == ADDR) && (bus_op_q == INVALIDATE)), .count(cnt_invalid)
    );

endmodule

// File: tb/tb_l2_bus_op_unit.sv
// Directed bench for l2_bus_op_unit with a transaction-level timing model.
module tb_l2_bus_op_unit;

    localparam int B   = 4;
    localparam int TMO = 15;
    localparam logic [31:0] MASK = 32'hFFFF_FFC0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cnt_read, cnt_write, cnt_modify, cnt_invalid;
    logic        err_snoop_tmo;

    l2_bus_op_unit_if #(.ADDR_W(32)) bif ();

    l2_bus_op_unit #(
        .ADDR_W(32), .OFFSET_W(6), .DATA_BEATS(B), .SNOOP_TMO(TMO), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .bif(bif),
        .cnt_read(cnt_read), .cnt_write(cnt_write),
        .cnt_modify(cnt_modify), .cnt_invalid(cnt_invalid),
        .err_snoop_tmo(err_snoop_tmo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Model of expected outputs keyed by cycle number.
    bit          exp_bv    [int];
    logic [2:0]  hold_op   [int];
    logic [31:0] hold_addr [int];
    bit          busy      [int];
    logic [1:0]  exp_rsp   [int];
    bit          exp_tmo   [int];
    int unsigned mc [4];            // read, write, modify, invalid

    bit          chk_en = 1'b0;
    bit          prev_bv = 1'b0;
    logic [31:0] last_bv_addr = '0;
    int          err_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int op_idx(input logic [2:0] op);
        case (op)
            3'd1:    return 0;
            3'd2:    return 1;
            3'd4:    return 2;
            default: return 3;
        endcase
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            check("req_ready", bif.req_ready, !busy.exists(cyc));
            check("bus_valid", bif.bus_valid, exp_bv.exists(cyc));
            check("bus_op", bif.bus_op, hold_op.exists(cyc) ? hold_op[cyc] : 3'd0);
            check("bus_addr", bif.bus_addr, hold_addr.exists(cyc) ? hold_addr[cyc] : 32'd0);
            check("rsp_valid", bif.rsp_valid, exp_rsp.exists(cyc));
            if (exp_rsp.exists(cyc)) check("rsp_snoop", bif.rsp_snoop, exp_rsp[cyc]);
            check("err_snoop_tmo", err_snoop_tmo, exp_tmo.exists(cyc));
            check("cnt_read", cnt_read, mc[0]);
            check("cnt_write", cnt_write, mc[1]);
            check("cnt_modify", cnt_modify, mc[2]);
            check("cnt_invalid", cnt_invalid, mc[3]);
            check("bus_valid_back_to_back", bif.bus_valid && prev_bv, 1'b0);
            prev_bv = bif.bus_valid;
            if (bif.bus_valid) last_bv_addr = bif.bus_addr;
            if (err_snoop_tmo) err_seen++;
            if (exp_bv.exists(cyc) && mc[op_idx(hold_op[cyc])] != 32'hFFFF_FFFF)
                mc[op_idx(hold_op[cyc])]++;
        end
    end

    task automatic clear_model();
        exp_bv.delete(); hold_op.delete(); hold_addr.delete();
        busy.delete(); exp_rsp.delete(); exp_tmo.delete();
        foreach (mc[i]) mc[i] = 0;
        prev_bv = 1'b0;
    endtask

    // d: snoop arrives d cycles after the address cycle (0 = never).
    // gap: idle cycles between beats. abort_beats>0: reset after that many beats.
    task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input int d,
                          input logic [1:0] snp, input int gap, input bit stray,
                          input bit hold, input int abort_beats,
                          output int c0, output int rc);
        int a, s, n, nb;
        bit legal, real_snp, is_beat;
        logic [1:0] res;
        int beat_at[$];
        bif.req_valid = 1'b1;
        bif.req_op    = op;
        bif.req_addr  = addr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bif.req_ready && n < 200);
        check("accepted", bif.req_ready, 1'b1);
        c0 = cyc;
        rc = cyc;
        if (!bif.req_ready) begin
            bif.req_valid = 1'b0;
            return;
        end
        legal    = (op >= 3'd1) && (op <= 3'd4);
        real_snp = (d >= 1) && (d <= TMO);
        a = c0 + 1;
        if (!legal) begin
            rc = c0 + 1;
            busy[rc] = 1'b1;
            exp_rsp[rc] = 2'b00;
        end else begin
            s   = a + (real_snp ? d : TMO);
            res = !real_snp ? 2'b00 : (snp == 2'b11 ? 2'b10 : snp);
            if (!real_snp) exp_tmo[s + 1] = 1'b1;
            if (op == 3'd3) begin
                rc = s + 1;
            end else begin
                for (int k = 0; k < B; k++) beat_at.push_back(s + 1 + k * (gap + 1));
                rc = beat_at[B - 1] + 1;
            end
            exp_bv[a] = 1'b1;
            for (int t = a; t <= rc; t++) begin
                hold_op[t]   = op;
                hold_addr[t] = addr & MASK;
                busy[t]      = 1'b1;
            end
            exp_rsp[rc] = res;
        end
        @(posedge clk); #1;
        if (!hold) bif.req_valid = 1'b0;
        nb = 0;
        for (int t = c0 + 1; t <= rc; t++) begin
            is_beat = 1'b0;
            foreach (beat_at[k]) if (beat_at[k] == t) is_beat = 1'b1;
            bif.bus_snoop_valid = legal && real_snp && (t == a + d);
            bif.bus_snoop       = bif.bus_snoop_valid ? snp : 2'b01;
            bif.bus_beat        = is_beat || (legal && stray && t == a);
            @(posedge clk); #1;
            if (is_beat) nb++;
            if (abort_beats > 0 && nb == abort_beats) begin
                rst = 1'b1;
                bif.bus_snoop_valid = 1'b0;
                bif.bus_beat = 1'b0;
                bif.req_valid = 1'b0;
                #1;
                check("abort_req_ready", bif.req_ready, 1'b1);
                check("abort_bus_valid", bif.bus_valid, 1'b0);
                check("abort_bus_op", bif.bus_op, 3'd0);
                check("abort_bus_addr", bif.bus_addr, 32'd0);
                check("abort_rsp_valid", bif.rsp_valid, 1'b0);
                check("abort_cnt_read", cnt_read, 32'd0);
                clear_model();
                return;
            end
        end
        bif.bus_snoop_valid = 1'b0;
        bif.bus_beat        = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0, rc, c1, rc1;
        bif.req_valid = 1'b0; bif.req_op = 3'd0; bif.req_addr = '0;
        bif.bus_snoop_valid = 1'b0; bif.bus_snoop = 2'b00; bif.bus_beat = 1'b0;
        foreach (mc[i]) mc[i] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", bif.req_ready, 1'b1);
        check("rst_rsp_valid", bif.rsp_valid, 1'b0);
        check("rst_rsp_snoop", bif.rsp_snoop, 2'b00);
        check("rst_bus_valid", bif.bus_valid, 1'b0);
        check("rst_bus_op", bif.bus_op, 3'd0);
        check("rst_bus_addr", bif.bus_addr, 32'd0);
        check("rst_err", err_snoop_tmo, 1'b0);
        check("rst_cnt_read", cnt_read, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // READ, HIT two cycles after ADDR, stray beat during ADDR ignored
        run_op(3'd1, 32'h1234_567F, 2, 2'b01, 0, 1'b1, 1'b0, 0, c0, rc);
        check("read_latency", rc - c0, 8);
        check("read_bus_addr", last_bv_addr, 32'h1234_5640);
        check("read_cnt", cnt_read, 32'd1);

        // INVALIDATE, immediate HITM: minimum latency
        run_op(3'd3, 32'h0000_1008, 1, 2'b10, 0, 1'b0, 1'b0, 0, c0, rc);
        check("inv_latency", rc - c0, 3);
        check("inv_cnt", cnt_invalid, 32'd1);

        // RFO with no snoop response: timeout, spaced beats
        run_op(3'd4, 32'hABCD_EF3F, 0, 2'b00, 1, 1'b0, 1'b0, 0, c0, rc);
        check("rfo_latency", rc - c0, 24);
        check("rfo_bus_addr", last_bv_addr, 32'hABCD_EF00);
        check("rfo_err_count", err_seen, 1);
        check("rfo_cnt", cnt_modify, 32'd1);

        // READ with snoop 2'b11 (HITM) and back-to-back beats: minimum latency
        run_op(3'd1, 32'h0000_0040, 1, 2'b11, 0, 1'b0, 1'b0, 0, c0, rc);
        check("read_min_latency", rc - c0, 7);
        check("read_cnt2", cnt_read, 32'd2);

        // Two WRITEs with req_valid held; first snoop arrives on the timeout cycle
        run_op(3'd2, 32'h0000_2000, 15, 2'b01, 0, 1'b0, 1'b1, 0, c0, rc);
        check("write1_latency", rc - c0, 21);
        run_op(3'd2, 32'h0000_3010, 1, 2'b00, 0, 1'b0, 1'b0, 0, c1, rc1);
        check("write2_accept_cycle", c1, rc + 1);
        check("write_cnt", cnt_write, 32'd2);
        check("no_extra_tmo", err_seen, 1);

        // Illegal op: local NOHIT response, no bus activity
        run_op(3'd6, 32'h0000_4000, 0, 2'b00, 0, 1'b0, 1'b0, 0, c0, rc);
        check("illegal_latency", rc - c0, 1);
        check("illegal_cnt_write", cnt_write, 32'd2);

        // Reset after the second data beat of a READ
        run_op(3'd1, 32'h0000_5000, 1, 2'b01, 0, 1'b0, 1'b0, 2, c0, rc);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_cnt_read", cnt_read, 32'd0);

        // Recovery after reset
        run_op(3'd3, 32'h0000_6000, 1, 2'b01, 0, 1'b0, 1'b0, 0, c0, rc);
        check("post_rst_cnt_invalid", cnt_invalid, 32'd1);
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
